// File: rtl/bf_data_mem_arbiter.sv
// Single-port data RAM arbiter: BF core ops (read/write/inc/dec as RMW) vs. host port, host starvation bounded by an aging counter.
// Optional whole-RAM zero-fill with clear_start/clear_done when BF_MEM_CLEAR_EN is defined.
module bf_data_mem_arbiter #(
  parameter int ADDR_W        = 15,
  parameter int DATA_W        = 8,
  parameter int HOST_MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
`ifdef BF_MEM_CLEAR_EN
  input  logic              clear_start,
  output logic              clear_done,
`endif
  input  logic              core_req,
  input  logic [1:0]        core_op,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_done,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_done,
  output logic [DATA_W-1:0] host_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  localparam logic [1:0] OP_RD  = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_INC = 2'b10;

  localparam int WAIT_W = $clog2(HOST_MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(HOST_MAX_WAIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WB,
    S_RESP
`ifdef BF_MEM_CLEAR_EN
    ,
    S_CLEAR
`endif
  } state_t;

  state_t              state, nxt;
  logic [1:0]          op_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   hold_q;
  logic                own_host_q;
  logic [WAIT_W-1:0]   wait_q;

  logic                host_win;
  logic [1:0]          sel_op;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                clr_go;
  logic                resp_clr;

`ifdef BF_MEM_CLEAR_EN
  logic [ADDR_W-1:0]   clr_cnt_q;
  logic                own_clr_q;
  assign clr_go   = clear_start;
  assign resp_clr = own_clr_q;
`else
  assign clr_go   = 1'b0;
  assign resp_clr = 1'b0;
`endif

  // Core has priority unless the host has lost HOST_MAX_WAIT arbitrations in a row.
  always_comb begin
    host_win  = host_req && (!core_req || (wait_q == WAIT_MAX));
    sel_op    = host_win ? {1'b0, host_we} : core_op;
    sel_addr  = host_win ? host_addr : core_addr;
    sel_wdata = host_win ? host_wdata : core_wdata;
  end

  always_comb begin
    nxt       = state;
    core_gnt  = 1'b0;
    host_gnt  = 1'b0;
    core_done = 1'b0;
    host_done = 1'b0;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    busy      = 1'b0;
`ifdef BF_MEM_CLEAR_EN
    clear_done = 1'b0;
`endif
    if (!reset) begin
      case (state)
        S_IDLE: begin
          if (clr_go) begin
`ifdef BF_MEM_CLEAR_EN
            nxt = S_CLEAR;
`endif
          end else if (core_req || host_req) begin
            host_gnt  = host_win;
            core_gnt  = !host_win;
            ram_en    = 1'b1;
            ram_we    = (sel_op == OP_WR);
            ram_addr  = sel_addr;
            ram_wdata = (sel_op == OP_WR) ? sel_wdata : '0;
            nxt       = (sel_op == OP_WR) ? S_RESP : S_RD;
          end
        end
        S_RD: begin
          busy = 1'b1;
          nxt  = (op_q == OP_RD) ? S_RESP : S_WB;
        end
        S_WB: begin
          busy      = 1'b1;
          ram_en    = 1'b1;
          ram_we    = 1'b1;
          ram_addr  = addr_q;
          ram_wdata = hold_q;
          nxt       = S_RESP;
        end
        S_RESP: begin
          busy      = 1'b1;
          core_done = !resp_clr && !own_host_q;
          host_done = !resp_clr && own_host_q;
`ifdef BF_MEM_CLEAR_EN
          clear_done = own_clr_q;
`endif
          nxt       = S_IDLE;
        end
`ifdef BF_MEM_CLEAR_EN
        S_CLEAR: begin
          busy     = 1'b1;
          ram_en   = 1'b1;
          ram_we   = 1'b1;
          ram_addr = clr_cnt_q;
          if (&clr_cnt_q) nxt = S_RESP;
        end
`endif
        default: nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      op_q       <= '0;
      addr_q     <= '0;
      hold_q     <= '0;
      own_host_q <= 1'b0;
      wait_q     <= '0;
      core_rdata <= '0;
      host_rdata <= '0;
`ifdef BF_MEM_CLEAR_EN
      clr_cnt_q  <= '0;
      own_clr_q  <= 1'b0;
`endif
    end else begin
      state <= nxt;
      if (core_gnt || host_gnt) begin
        op_q       <= sel_op;
        addr_q     <= sel_addr;
        own_host_q <= host_gnt;
`ifdef BF_MEM_CLEAR_EN
        own_clr_q  <= 1'b0;
`endif
      end
      if (host_gnt) wait_q <= '0;
      else if (core_gnt && host_req && (wait_q != WAIT_MAX)) wait_q <= wait_q + 1'b1;

      if (state == S_RD) begin
        if (op_q == OP_RD) begin
          if (own_host_q) host_rdata <= ram_rdata;
          else            core_rdata <= ram_rdata;
        end else begin
          hold_q <= (op_q == OP_INC) ? ram_rdata + DATA_W'(1) : ram_rdata - DATA_W'(1);
        end
      end
      // Only the core issues inc/dec, so the written-back value is its response.
      if (state == S_WB) core_rdata <= hold_q;

`ifdef BF_MEM_CLEAR_EN
      if (state == S_IDLE && clr_go) begin
        clr_cnt_q <= '0;
        own_clr_q <= 1'b1;
      end
      if (state == S_CLEAR) clr_cnt_q <= clr_cnt_q + 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_bf_data_mem_arbiter.sv
// Scoreboard bench for bf_data_mem_arbiter: directed ops push expected responses, a negedge monitor checks done pulses.
module tb_bf_data_mem_arbiter;
`ifdef BF_MEM_CLEAR_EN
  localparam int AW = 4;
`else
  localparam int AW = 15;
`endif
  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic core_req = 1'b0, host_req = 1'b0, host_we = 1'b0;
  logic [1:0] core_op = 2'b00;
  logic [AW-1:0] core_addr = '0, host_addr = '0;
  logic [DW-1:0] core_wdata = '0, host_wdata = '0;
  logic core_gnt, core_done, host_gnt, host_done, ram_en, ram_we, busy;
  logic [DW-1:0] core_rdata, host_rdata, ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
  logic [AW-1:0] ram_addr;
`ifdef BF_MEM_CLEAR_EN
  logic clear_start = 1'b0;
  logic clear_done;
`endif

  bf_data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .HOST_MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
`ifdef BF_MEM_CLEAR_EN
    .clear_start(clear_start), .clear_done(clear_done),
`endif
    .core_req(core_req), .core_op(core_op), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_done(core_done), .core_rdata(core_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_done(host_done), .host_rdata(host_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  typedef struct { logic [DW-1:0] d; bit chk_d; int lat; } exp_t;
  exp_t core_q[$], host_q[$];
  int core_gq[$], host_gq[$];
  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: timestamps grants, pops expectations on each done pulse.
  always @(negedge clk) begin
    exp_t e;
    int g;
    if (reset) begin
      core_gq.delete();
      host_gq.delete();
    end else begin
      if (core_gnt && host_gnt) chk("dual_gnt", 1, 0);
      if (core_gnt) core_gq.push_back(cyc);
      if (host_gnt) host_gq.push_back(cyc);
      if (core_done) begin
        if (core_q.size() == 0 || core_gq.size() == 0) chk("core_done_unexpected", 1, 0);
        else begin
          e = core_q.pop_front();
          g = core_gq.pop_front();
          chk("core_latency", cyc - g, e.lat);
          if (e.chk_d) chk("core_rdata", core_rdata, e.d);
        end
      end
      if (host_done) begin
        if (host_q.size() == 0 || host_gq.size() == 0) chk("host_done_unexpected", 1, 0);
        else begin
          e = host_q.pop_front();
          g = host_gq.pop_front();
          chk("host_latency", cyc - g, e.lat);
          if (e.chk_d) chk("host_rdata", host_rdata, e.d);
        end
      end
    end
  end

  task automatic wait_core_gnt();
    int n = 0;
    do begin @(negedge clk); n++; end while (!core_gnt && n < 50);
    if (!core_gnt) chk("core_gnt_timeout", 0, 1);
  endtask

  task automatic core_op_t(input logic [1:0] op, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd, input logic [DW-1:0] exp, input int lat);
    exp_t e;
    e.d = exp; e.chk_d = (op != 2'b01); e.lat = lat;
    core_q.push_back(e);
    @(posedge clk); #1;
    core_req = 1'b1; core_op = op; core_addr = a; core_wdata = wd;
    wait_core_gnt();
    chk("core_issue_en", ram_en, 1);
    chk("core_issue_we", ram_we, (op == 2'b01));
    chk("core_issue_addr", ram_addr, a);
    @(posedge clk); #1;
    core_req = 1'b0;
    if (op[1]) begin
      repeat (2) @(negedge clk);
      chk("wb_en_we", {ram_en, ram_we}, 2'b11);
      chk("wb_addr", ram_addr, a);
      chk("wb_data", ram_wdata, exp);
    end
    repeat (4) @(posedge clk);
  endtask

  task automatic host_op_t(input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd, input logic [DW-1:0] exp);
    exp_t e;
    int n = 0;
    e.d = exp; e.chk_d = !we; e.lat = we ? 1 : 2;
    host_q.push_back(e);
    @(posedge clk); #1;
    host_req = 1'b1; host_we = we; host_addr = a; host_wdata = wd;
    do begin @(negedge clk); n++; end while (!host_gnt && n < 50);
    if (!host_gnt) chk("host_gnt_timeout", 0, 1);
    chk("host_issue_addr", ram_addr, a);
    chk("host_core_idle", {core_gnt, core_done}, 2'b00);
    @(posedge clk); #1;
    host_req = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a live request: nothing may leak out.
    core_req = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", {core_gnt, host_gnt}, 2'b00);
    chk("rst_ram_en", ram_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_core_rdata", core_rdata, 0);
    chk("rst_host_rdata", host_rdata, 0);
    @(posedge clk); #1;
    reset = 1'b0; core_req = 1'b0;
    repeat (2) @(posedge clk);

    // Write/read, inc/dec with wrap, host-only traffic.
    core_op_t(2'b01, 5, 8'h41, 8'h00, 1);
    core_op_t(2'b00, 5, 8'h00, 8'h41, 2);
    host_op_t(1'b1, 9, 8'hFF, 8'h00);
    core_op_t(2'b10, 9, 8'h00, 8'h00, 3);
    core_op_t(2'b11, 9, 8'h00, 8'hFF, 3);
    host_op_t(1'b1, 10, 8'h10, 8'h00);
    core_op_t(2'b11, 10, 8'h00, 8'h0F, 3);
    core_op_t(2'b10, 10, 8'h00, 8'h10, 3);
    host_op_t(1'b1, 3, 8'h7A, 8'h00);
    host_op_t(1'b0, 3, 8'h00, 8'h7A);

    // Both requesters held: C,C,C,C,H repeating.
    begin
      exp_t e;
      int k = 0, n = 0;
      for (int i = 0; i < 10; i++) begin
        e.chk_d = 1'b1; e.lat = 2;
        if (i % 5 == 4) begin e.d = 8'h7A; host_q.push_back(e); end
        else            begin e.d = 8'h41; core_q.push_back(e); end
      end
      @(posedge clk); #1;
      core_req = 1'b1; core_op = 2'b00; core_addr = 5;
      host_req = 1'b1; host_we = 1'b0; host_addr = 3;
      while (k < 10 && n < 200) begin
        @(negedge clk); n++;
        if (core_gnt || host_gnt) begin
          chk("arb_order_host", host_gnt, (k % 5 == 4));
          k++;
          if (k == 10) begin
            @(posedge clk); #1;
            core_req = 1'b0; host_req = 1'b0;
          end
        end
      end
      if (k < 10) begin
        chk("arb_grant_timeout", k, 10);
        core_req = 1'b0; host_req = 1'b0;
      end
      repeat (5) @(posedge clk);
    end

    // Reset during the write-back of an inc drops the op.
    host_op_t(1'b1, 12, 8'h33, 8'h00);
    @(posedge clk); #1;
    core_req = 1'b1; core_op = 2'b10; core_addr = 12;
    wait_core_gnt();
    @(posedge clk); #1;
    core_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rstwb_ram_en", ram_en, 0);
    chk("rstwb_done", {core_done, host_done}, 2'b00);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_ram_en", ram_en, 0);
    chk("post_rst_core_rdata", core_rdata, 0);
    chk("post_rst_host_rdata", host_rdata, 0);
    repeat (3) @(posedge clk);
    host_op_t(1'b0, 12, 8'h00, 8'h33);
    core_op_t(2'b00, 12, 8'h00, 8'h33, 2);

`ifdef BF_MEM_CLEAR_EN
    begin
      exp_t e;
      e.d = 8'h00; e.chk_d = 1'b1; e.lat = 2;
      core_q.push_back(e);
      @(posedge clk); #1;
      clear_start = 1'b1; core_req = 1'b1; core_op = 2'b00; core_addr = 5;
      @(negedge clk);
      chk("clr_start_gnt", core_gnt, 0);
      @(posedge clk); #1;
      clear_start = 1'b0;
      for (int i = 0; i < 16; i++) begin
        @(negedge clk);
        chk("clr_gnt", core_gnt, 0);
        chk("clr_en_we", {ram_en, ram_we}, 2'b11);
        chk("clr_addr", ram_addr, i);
        chk("clr_data", ram_wdata, 0);
      end
      @(negedge clk);
      chk("clr_done", clear_done, 1);
      chk("clr_done_gnt", core_gnt, 0);
      @(negedge clk);
      chk("clr_then_gnt", core_gnt, 1);
      @(posedge clk); #1;
      core_req = 1'b0;
      repeat (4) @(posedge clk);
    end
`endif

    repeat (5) @(negedge clk);
    chk("core_q_drained", core_q.size(), 0);
    chk("host_q_drained", host_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
